// File: rtl/fnd_pkg.sv
// Shared constants and types for the 6-digit multiplexed 7-segment display.
package fnd_pkg;

  localparam int DIGITS = 6;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Slots that carry a decimal point (after seconds units and minutes units)
  localparam logic [5:0] DP_MASK = 6'b010100;

  // Slot numbering, least significant digit first
  typedef enum logic [2:0] {
    SLOT_CC_U = 3'd0,
    SLOT_CC_T = 3'd1,
    SLOT_SS_U = 3'd2,
    SLOT_SS_T = 3'd3,
    SLOT_MM_U = 3'd4,
    SLOT_MM_T = 3'd5
  } slot_e;

  // One complete time value as BCD pairs
  typedef struct packed {
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] cc;
  } bcd_frame_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup with blanking taking priority over the digit value
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_6digit.sv
// Time-multiplexed driver for a common-anode 6-digit display with frame-aligned
// updates, per-slot dead time, leading-zero blanking and blink.
module fnd_scan_6digit
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_i,
  input  logic [7:0] mm_i,
  input  logic [7:0] ss_i,
  input  logic [7:0] cc_i,
  input  logic       lzb_i,
  input  logic       blink_i,
  output logic [7:0] seg_o,
  output logic [5:0] com_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END = PW'(DEAD);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  bcd_frame_t    shadow;
  bcd_frame_t    disp;
  logic [FW-1:0] frm_cnt;
  logic          phase;

  logic          pre_wrap;
  logic          frame_start;
  logic [3:0]    nib;
  logic          dp_slot;
  logic          blank;
  logic [6:0]    seg_pat;
  logic [7:0]    seg_nxt;
  logic [5:0]    com_nxt;

  assign pre_wrap    = (pre == PRE_LAST);
  assign frame_start = pre_wrap && (idx == IDX_LAST);

  // Prescaler and slot index: idx steps once per SCAN_DIV cycles, 0..5
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_wrap) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Shadow takes loads at any time; display only copies it at frame start so a
  // frame never mixes old and new digits. The copy sees the pre-edge shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (ld_i) begin
        shadow <= '{mm: mm_i, ss: ss_i, cc: cc_i};
      end
      if (frame_start) begin
        disp <= shadow;
      end
    end
  end

  // Blink timing: count frames and flip the phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (!blink_i) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (frame_start) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt <= '0;
        phase   <= ~phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  // Pick the nibble for the active slot and decide blanking; lzb_i is used live
  always_comb begin
    nib     = 4'd0;
    dp_slot = 1'b0;
    blank   = 1'b0;
    case (idx)
      SLOT_CC_U: nib = disp.cc[3:0];
      SLOT_CC_T: nib = disp.cc[7:4];
      SLOT_SS_U: nib = disp.ss[3:0];
      SLOT_SS_T: nib = disp.ss[7:4];
      SLOT_MM_U: nib = disp.mm[3:0];
      SLOT_MM_T: begin
        nib   = disp.mm[7:4];
        blank = lzb_i && (disp.mm[7:4] == 4'd0);
      end
      default:   nib = 4'd0;
    endcase
    if (idx < 3'(DIGITS)) begin
      dp_slot = DP_MASK[idx];
    end
  end

  bcd_to_seg7 u_dec (
    .nib   (nib),
    .blank (blank),
    .seg   (seg_pat)
  );

  // Next pin values: dead time first, then the selected common unless blinking dark
  always_comb begin
    seg_nxt = 8'hFF;
    com_nxt = 6'h3F;
    if (pre >= DEAD_END) begin
      seg_nxt = {~(dp_slot && !blank), seg_pat};
      if (!(blink_i && phase)) begin
        com_nxt = ~(6'd1 << idx);
      end
    end
  end

  // Registered pins so segments and commons switch on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_o <= 8'hFF;
      com_o <= 6'h3F;
    end else begin
      seg_o <= seg_nxt;
      com_o <= com_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_6digit.sv
// Directed bench for fnd_scan_6digit with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2.
// cyc counts falling edges since reset release; the pins seen at cyc n come
// from the state after rising edge n-1, so slot k of frame f is lit for
// cyc = 48f+8k+3 .. 48f+8k+8.
module tb_fnd_scan_6digit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_i = 1'b0;
  logic [7:0] mm_i = 8'h00;
  logic [7:0] ss_i = 8'h00;
  logic [7:0] cc_i = 8'h00;
  logic       lzb_i = 1'b0;
  logic       blink_i = 1'b0;
  logic [7:0] seg_o;
  logic [5:0] com_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  fnd_scan_6digit #(
    .SCAN_DIV     (8),
    .DEAD         (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (ld_i),
    .mm_i    (mm_i),
    .ss_i    (ss_i),
    .cc_i    (cc_i),
    .lzb_i   (lzb_i),
    .blink_i (blink_i),
    .seg_o   (seg_o),
    .com_o   (com_o)
  );

  always #5 clk = ~clk;

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (seg_o !== 8'hFF || com_o !== 6'h3F) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: seg=%h com=%b expected seg=ff com=111111", seg_o, com_o);
    end
    rst = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 9; n++) begin
      logic [5:0] exp_com;
      goto(n);
      exp_com = (n >= 3 && n <= 8) ? 6'b111110 : 6'b111111;
      vectors++;
      if (com_o !== exp_com) begin
        miscompares++;
        $display("[TB] FAIL reset_release_c%0d: com=%b expected %b", n, com_o, exp_com);
      end
    end
  endtask

  task automatic test_load();
    int         at [6];
    logic [5:0] ec [6];
    logic [7:0] es [6];
    goto(10);
    mm_i = 8'h12; ss_i = 8'h34; cc_i = 8'h56; ld_i = 1'b1;
    goto(11);
    ld_i = 1'b0;
    at = '{19, 43, 51, 67, 83, 91};
    ec = '{6'b111011, 6'b011111, 6'b111110, 6'b111011, 6'b101111, 6'b011111};
    es = '{8'h40, 8'hC0, 8'h82, 8'h19, 8'h24, 8'hF9};
    for (int i = 0; i < 6; i++) begin
      goto(at[i]);
      vectors++;
      if (com_o !== ec[i] || seg_o !== es[i]) begin
        miscompares++;
        $display("[TB] FAIL load_c%0d: com=%b seg=%h expected com=%b seg=%h",
                 at[i], com_o, seg_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_collision();
    int         at [3];
    logic [5:0] ec [3];
    logic [7:0] es [3];
    goto(95);
    mm_i = 8'h78; ss_i = 8'h90; cc_i = 8'h21; ld_i = 1'b1;
    goto(96);
    ld_i = 1'b0;
    at = '{99, 147, 187};
    ec = '{6'b111110, 6'b111110, 6'b011111};
    es = '{8'h82, 8'hF9, 8'hF8};
    for (int i = 0; i < 3; i++) begin
      goto(at[i]);
      vectors++;
      if (com_o !== ec[i] || seg_o !== es[i]) begin
        miscompares++;
        $display("[TB] FAIL collision_c%0d: com=%b seg=%h expected com=%b seg=%h",
                 at[i], com_o, seg_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_blank_invalid();
    int         at [5];
    logic [5:0] ec [5];
    logic [7:0] es [5];
    goto(188);
    mm_i = 8'h99; ss_i = 8'h99; cc_i = 8'h99; ld_i = 1'b1;
    goto(189);
    mm_i = 8'h05; ss_i = 8'h00; cc_i = 8'h9A; lzb_i = 1'b1;
    goto(190);
    ld_i = 1'b0;
    at = '{195, 203, 227, 235, 283};
    ec = '{6'b111110, 6'b111101, 6'b101111, 6'b011111, 6'b011111};
    es = '{8'hBF, 8'h90, 8'h12, 8'hFF, 8'hC0};
    for (int i = 0; i < 5; i++) begin
      goto(at[i]);
      vectors++;
      if (com_o !== ec[i] || seg_o !== es[i]) begin
        miscompares++;
        $display("[TB] FAIL blank_c%0d: com=%b seg=%h expected com=%b seg=%h",
                 at[i], com_o, seg_o, ec[i], es[i]);
      end
      if (at[i] == 235) begin
        goto(236);
        lzb_i = 1'b0;
      end
    end
  endtask

  task automatic test_blink();
    int         at [7];
    logic [5:0] ec [7];
    goto(288);
    blink_i = 1'b1;
    at = '{291, 363, 387, 467, 491, 531, 587};
    ec = '{6'b111110, 6'b110111, 6'b111111, 6'b111111, 6'b111101, 6'b111110, 6'b111111};
    for (int i = 0; i < 7; i++) begin
      goto(at[i]);
      vectors++;
      if (com_o !== ec[i]) begin
        miscompares++;
        $display("[TB] FAIL blink_c%0d: com=%b expected %b", at[i], com_o, ec[i]);
      end
    end
    goto(590);
    blink_i = 1'b0;
    goto(595);
    vectors++;
    if (com_o !== 6'b111011 || seg_o !== 8'h40) begin
      miscompares++;
      $display("[TB] FAIL blink_drop: com=%b seg=%h expected com=111011 seg=40", com_o, seg_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    int         at [3];
    logic [5:0] ec [3];
    goto(652);
    rst = 1'b0;
    #1;
    vectors++;
    if (seg_o !== 8'hFF || com_o !== 6'h3F) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async: seg=%h com=%b expected seg=ff com=111111", seg_o, com_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    at = '{3, 9, 11};
    ec = '{6'b111110, 6'b111111, 6'b111101};
    for (int i = 0; i < 3; i++) begin
      goto(at[i]);
      vectors++;
      if (com_o !== ec[i]) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_c%0d: com=%b expected %b", at[i], com_o, ec[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_collision();
    test_blank_invalid();
    test_blink();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
